lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Clocked load/store unit between the core's memory-stage request interface and the asynchronous RAM data port (write_enable/read_enable/bw/write_address/read_address/data_in/data_out).
- Accepts one load or store per handshake and checks alignment.
- Drives RAM control with stable, registered levels.
- Captures read data, then sign- or zero-extends it.
- Diverts stores to the console address to a separate tohost port.

Parameters:
- MEM_LATENCY, 1: cycles read_enable/read_address are held before mem_data_out is sampled (legal range 1..15).
- TOHOST_ADDR, 32'h80001000: store address routed to the tohost port instead of the RAM.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word (11 treated as word).
- req_unsigned  in  1  zero-extend a load (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  misaligned access.
- mem_write_enable  out  1  to RAM write_enable.
- mem_read_enable  out  1  to RAM read_enable.
- mem_bw  out  2  to RAM bw: 01 byte, 10 half, 11 word.
- mem_write_address  out  32  to RAM write_address.
- mem_read_address  out  32  to RAM read_address.
- mem_data_in  out  32  to RAM data_in.
- mem_data_out  in  32  from RAM data_out; byte at the address is in [7:0].
- tohost_valid  out  1  one-cycle pulse on a console store.
- tohost_data  out  32  the console store's data.

Behaviour:
Reset (rst=0, async):
- State goes to IDLE; latency counter cleared.
- All outputs 0, including req_ready.
- req_ready rises on the first clk edge after reset is released.
- A reset mid-operation abandons the access: enables drop immediately and no response is produced.

FSM states: IDLE, WRITE, READ, RESP.
- IDLE: req_ready=1. On req_valid & req_ready, latch we/size/unsigned/addr/wdata; req_ready=0 from the next cycle.
- Misalignment check on accept:
  - half with addr[0]=1 is misaligned;
  - word with addr[1:0]!=0 is misaligned;
  - on misalignment: no RAM access, go to RESP with rsp_fault=1 and rsp_rdata=0.
- Store to TOHOST_ADDR: tohost_valid=1 with tohost_data=wdata for exactly one cycle (the cycle after accept); no RAM write; go to RESP.
- Other stores → WRITE for exactly 1 cycle, then RESP.
  - During WRITE: mem_write_enable=1, mem_write_address=addr, mem_data_in=wdata, mem_bw per size.
  - mem_write_address, mem_data_in and mem_bw are set up in the same register update as the enable, so the address never changes while the enable is high.
  - The enable deasserts on entering RESP; the address stays held until the next accept.
- Loads → READ.
  - mem_read_enable=1 and mem_read_address=addr for MEM_LATENCY cycles.
  - At the last READ cycle's edge, capture and extend mem_data_out:
    - byte: [7:0], extended from bit 7;
    - half: [15:0], extended from bit 15;
    - word: unchanged.
  - The enable drops on entering RESP.
- RESP: rsp_valid=1 with rsp_rdata/rsp_fault held stable until rsp_ready.
  - On rsp_valid & rsp_ready, return to IDLE.
  - req_ready rises the cycle after the response handshake, so there is no back-to-back acceptance in the same cycle.
- Latency, accept edge to rsp_valid:
  - store: 2 cycles;
  - load: MEM_LATENCY+1 cycles;
  - fault or tohost: 1 cycle.
- mem_bw idles at 00 when no write is active.
- Address wrap: no range check here; the RAM handles range.

Test Plan:
1. Reset then SW addr=0x100 data=0xDEADBEEF → one cycle of mem_write_enable=1, bw=11, address 0x100; rsp_valid 2 cycles after accept, rsp_fault=0, rsp_rdata=0.
2. LB addr=0x101 with mem_data_out=0x000000F0 (MEM_LATENCY=1) → rsp_rdata=0xFFFFFFF0. Same access as LBU → rsp_rdata=0x000000F0.
3. LH addr=0x103 → rsp_fault=1, rsp_rdata=0, mem_read_enable never asserted. LW addr=0x102 → rsp_fault=1.
4. SB addr=TOHOST_ADDR data=0x41 → tohost_valid single pulse with tohost_data=0x41; mem_write_enable stays 0.
5. Hold rsp_ready=0 for 5 cycles after a load → rsp_valid and rsp_rdata stable, req_ready=0 throughout; release → IDLE, req_ready=1 on the next cycle.
6. Assert rst=0 mid-READ with MEM_LATENCY=4 → mem_read_enable falls immediately, no rsp_valid; after release a fresh LW addr=0x200 completes normally.

Source files
------------

// File: rtl/lsu_mem_port_if.sv
// Core-side request/response channel of the load/store unit.
`timescale 1ns/1ps
interface lsu_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit between the memory-stage request channel and an asynchronous RAM port.
// Alignment check, registered RAM controls, load extension and console-store diversion.
//
// state | meaning
// IDLE  | ready for a request (req_ready high once out of reset)
// WRITE | single cycle with mem_write_enable asserted
// READ  | mem_read_enable held for MEM_LATENCY cycles, data captured on the last edge
// RESP  | response held until rsp_ready
`timescale 1ns/1ps
module lsu_mem_port #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000
) (
    input  logic        clk,
    input  logic        rst,
    lsu_mem_port_if.slave core,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [1:0]  mem_bw,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_read_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        tohost_valid,
    output logic [31:0] tohost_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic        req_ready_q;
    logic [3:0]  lat_cnt;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_fault_q;
    logic        accept;
    logic        misaligned;
    logic        to_tohost;
    logic        read_done;

    function automatic logic [1:0] bw_of(input logic [1:0] size);
        logic [1:0] bw;
        case (size)
            2'b00:   bw = 2'b01;
            2'b01:   bw = 2'b10;
            default: bw = 2'b11;
        endcase
        return bw;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                           input logic uns);
        logic [31:0] r;
        case (size)
            2'b00:   r = {{24{d[7] & ~uns}}, d[7:0]};
            2'b01:   r = {{16{d[15] & ~uns}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign accept    = (state == IDLE) && core.req_valid && req_ready_q;
    assign to_tohost = core.req_we && (core.req_addr == TOHOST_ADDR);
    assign read_done = (state == READ) && (lat_cnt == 4'd0);

    always_comb begin
        misaligned = 1'b0;
        case (core.req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = core.req_addr[0];
            default: misaligned = (core.req_addr[1:0] != 2'b00);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned)        state_nxt = RESP;
                    else if (!core.req_we) state_nxt = READ;
                    else if (to_tohost)    state_nxt = RESP;
                    else                   state_nxt = WRITE;
                end
            end
            WRITE:   state_nxt = RESP;
            READ:    state_nxt = read_done ? RESP : READ;
            RESP:    state_nxt = core.rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM controls are loaded at accept together with their enable, so address and data
    // are already stable on the first cycle the enable is seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready_q       <= 1'b0;
            lat_cnt           <= 4'd0;
            size_q            <= 2'b00;
            unsigned_q        <= 1'b0;
            rsp_rdata_q       <= 32'd0;
            rsp_fault_q       <= 1'b0;
            mem_write_enable  <= 1'b0;
            mem_read_enable   <= 1'b0;
            mem_bw            <= 2'b00;
            mem_write_address <= 32'd0;
            mem_read_address  <= 32'd0;
            mem_data_in       <= 32'd0;
            tohost_valid      <= 1'b0;
            tohost_data       <= 32'd0;
        end else begin
            req_ready_q  <= (state_nxt == IDLE);
            tohost_valid <= 1'b0;
            if (accept) begin
                size_q      <= core.req_size;
                unsigned_q  <= core.req_unsigned;
                rsp_rdata_q <= 32'd0;
                rsp_fault_q <= misaligned;
                lat_cnt     <= LAT_LOAD;
                if (!misaligned) begin
                    if (!core.req_we) begin
                        mem_read_enable  <= 1'b1;
                        mem_read_address <= core.req_addr;
                    end else if (to_tohost) begin
                        tohost_valid <= 1'b1;
                        tohost_data  <= core.req_wdata;
                    end else begin
                        mem_write_enable  <= 1'b1;
                        mem_write_address <= core.req_addr;
                        mem_data_in       <= core.req_wdata;
                        mem_bw            <= bw_of(core.req_size);
                    end
                end
            end
            if (state == WRITE) begin
                mem_write_enable <= 1'b0;
                mem_bw           <= 2'b00;
            end
            if (state == READ) begin
                if (read_done) begin
                    mem_read_enable <= 1'b0;
                    rsp_rdata_q     <= extend(mem_data_out, size_q, unsigned_q);
                end else begin
                    lat_cnt <= lat_cnt - 4'd1;
                end
            end
        end
    end

    assign core.req_ready = req_ready_q;
    assign core.rsp_valid = (state == RESP);
    assign core.rsp_rdata = rsp_rdata_q;
    assign core.rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: two instances (latency 1 and 4) driven in lockstep against
// a byte-array memory model; loads are predicted from the bench's own copy of memory.
`timescale 1ns/1ps
module tb_lsu_mem_port;
    localparam logic [31:0] TOHOST = 32'h8000_1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid    = 1'b0;
    logic        req_we       = 1'b0;
    logic [1:0]  req_size     = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr     = 32'd0;
    logic [31:0] req_wdata    = 32'd0;
    logic [1:0]  rsp_ready    = 2'b00;

    wire [1:0]        req_ready, rsp_valid, rsp_fault, mwe, mre, thv;
    wire [1:0][31:0]  rsp_rdata, mwa, mra, mdi, mdo, thd;
    wire [1:0][1:0]   mbw;

    int tests = 0;
    int fails = 0;
    logic [7:0] ref_mem [0:4095];

    function automatic logic [7:0] init_byte(input int k);
        return 8'((k * 37 + 11) ^ (k >> 3));
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        lsu_mem_port_if bus ();
        logic [7:0]  ram [0:4095];
        logic [11:0] ra;
        logic [11:0] wa;

        assign bus.req_valid    = req_valid;
        assign bus.req_we       = req_we;
        assign bus.req_size     = req_size;
        assign bus.req_unsigned = req_unsigned;
        assign bus.req_addr     = req_addr;
        assign bus.req_wdata    = req_wdata;
        assign bus.rsp_ready    = rsp_ready[g];
        assign req_ready[g]     = bus.req_ready;
        assign rsp_valid[g]     = bus.rsp_valid;
        assign rsp_rdata[g]     = bus.rsp_rdata;
        assign rsp_fault[g]     = bus.rsp_fault;

        assign ra     = mra[g][11:0];
        assign wa     = mwa[g][11:0];
        assign mdo[g] = {ram[ra + 12'd3], ram[ra + 12'd2], ram[ra + 12'd1], ram[ra]};

        initial for (int k = 0; k < 4096; k++) ram[k] = init_byte(k);

        always @(posedge clk) begin
            if (mwe[g]) begin
                ram[wa] = mdi[g][7:0];
                if (mbw[g][1]) ram[wa + 12'd1] = mdi[g][15:8];
                if (mbw[g] == 2'b11) begin
                    ram[wa + 12'd2] = mdi[g][23:16];
                    ram[wa + 12'd3] = mdi[g][31:24];
                end
            end
        end

        lsu_mem_port #(.MEM_LATENCY(lat_of(g)), .TOHOST_ADDR(TOHOST)) dut (
            .clk               (clk),
            .rst               (rst),
            .core              (bus),
            .mem_write_enable  (mwe[g]),
            .mem_read_enable   (mre[g]),
            .mem_bw            (mbw[g]),
            .mem_write_address (mwa[g]),
            .mem_read_address  (mra[g]),
            .mem_data_in       (mdi[g]),
            .mem_data_out      (mdo[g]),
            .tohost_valid      (thv[g]),
            .tohost_data       (thd[g])
        );
    end

    // One request issued to both instances; each is tracked until its response handshake.
    task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input string tag);
        int          nbytes, c, exp_lat;
        logic        exp_fault, exp_th, exp_wr, exp_rd;
        logic [31:0] exp_data, raw;
        logic [1:0]  exp_bw;
        int          lat [2], wen [2], ren [2], thn [2], held [2];
        logic [31:0] rd [2], thdat [2];
        logic        flt [2];
        bit          done [2], pend [2], bad_wr [2], bad_rd [2], unstable [2], bad_rdy [2], bad_post [2];

        nbytes    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        exp_fault = (addr % nbytes) != 0;
        exp_th    = we && !exp_fault && (addr == TOHOST);
        exp_wr    = we && !exp_fault && !exp_th;
        exp_rd    = !we && !exp_fault;
        exp_bw    = (nbytes == 1) ? 2'b01 : (nbytes == 2) ? 2'b10 : 2'b11;
        exp_data  = 32'd0;
        if (exp_rd) begin
            raw = 32'd0;
            for (int b = 0; b < nbytes; b++) raw |= 32'(ref_mem[12'(addr + b)]) << (8 * b);
            if (!uns && nbytes < 4 && raw[8 * nbytes - 1]) raw |= ~32'd0 << (8 * nbytes);
            exp_data = raw;
        end
        if (exp_wr)
            for (int b = 0; b < nbytes; b++) ref_mem[12'(addr + b)] = wdata[8 * b +: 8];

        c = 0;
        while (req_ready !== 2'b11 && c < 20) begin
            @(posedge clk); #1; c++;
        end
        tests++;
        if (req_ready !== 2'b11) begin
            fails++;
            $display("FAIL %s ready_wait: req_ready=%b, required 11", tag, req_ready);
        end

        for (int i = 0; i < 2; i++) begin
            lat[i] = 0; wen[i] = 0; ren[i] = 0; thn[i] = 0; held[i] = 0;
            rd[i] = 'x; thdat[i] = 'x; flt[i] = 1'bx;
            done[i] = 0; pend[i] = 0; bad_wr[i] = 0; bad_rd[i] = 0;
            unstable[i] = 0; bad_rdy[i] = 0; bad_post[i] = 0;
            rsp_ready[i] = (hold == 0);
        end

        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        c = 1;
        while (!(done[0] && done[1]) && c <= 60) begin
            for (int i = 0; i < 2; i++) begin
                if (done[i]) continue;
                if (pend[i]) begin
                    if (rsp_valid[i] !== 1'b0 || req_ready[i] !== 1'b1) bad_post[i] = 1;
                    done[i] = 1;
                    rsp_ready[i] = 1'b0;
                    continue;
                end
                if (req_ready[i] !== 1'b0) bad_rdy[i] = 1;
                if (mwe[i] === 1'b1) begin
                    wen[i]++;
                    if (mwa[i] !== addr || mdi[i] !== wdata || mbw[i] !== exp_bw) bad_wr[i] = 1;
                end else if (mbw[i] !== 2'b00) begin
                    bad_wr[i] = 1;
                end
                if (mre[i] === 1'b1) begin
                    ren[i]++;
                    if (mra[i] !== addr) bad_rd[i] = 1;
                end
                if (thv[i] === 1'b1) begin
                    thn[i]++;
                    thdat[i] = thd[i];
                end
                if (rsp_valid[i] === 1'b1) begin
                    if (lat[i] == 0) begin
                        lat[i] = c; rd[i] = rsp_rdata[i]; flt[i] = rsp_fault[i];
                    end else if (rsp_rdata[i] !== rd[i] || rsp_fault[i] !== flt[i]) begin
                        unstable[i] = 1;
                    end
                    if (!rsp_ready[i]) begin
                        held[i]++;
                        if (held[i] > hold) rsp_ready[i] = 1'b1;
                    end
                    if (rsp_ready[i]) pend[i] = 1;
                end
            end
            @(posedge clk); #1; c++;
        end

        for (int i = 0; i < 2; i++) begin
            exp_lat = (exp_fault || exp_th) ? 1 : (we ? 2 : lat_of(i) + 1);
            tests++;
            if (!done[i]) begin
                fails++; $display("FAIL %s[L%0d] timeout: no response handshake within 60 cycles", tag, lat_of(i));
            end
            tests++;
            if (lat[i] != exp_lat) begin
                fails++; $display("FAIL %s[L%0d] latency: got %0d, required %0d", tag, lat_of(i), lat[i], exp_lat);
            end
            tests++;
            if (rd[i] !== exp_data) begin
                fails++; $display("FAIL %s[L%0d] rdata: got %h, required %h", tag, lat_of(i), rd[i], exp_data);
            end
            tests++;
            if (flt[i] !== exp_fault) begin
                fails++; $display("FAIL %s[L%0d] fault: got %b, required %b", tag, lat_of(i), flt[i], exp_fault);
            end
            tests++;
            if (wen[i] != (exp_wr ? 1 : 0)) begin
                fails++; $display("FAIL %s[L%0d] write_cycles: got %0d, required %0d", tag, lat_of(i), wen[i], exp_wr ? 1 : 0);
            end
            tests++;
            if (bad_wr[i]) begin
                fails++; $display("FAIL %s[L%0d] write_bus: addr/data/bw wrong, bw=%b required %b", tag, lat_of(i), mbw[i], exp_bw);
            end
            tests++;
            if (ren[i] != (exp_rd ? lat_of(i) : 0) || bad_rd[i]) begin
                fails++; $display("FAIL %s[L%0d] read_cycles: got %0d (addr_bad=%0d), required %0d", tag, lat_of(i), ren[i], bad_rd[i], exp_rd ? lat_of(i) : 0);
            end
            tests++;
            if (thn[i] != (exp_th ? 1 : 0)) begin
                fails++; $display("FAIL %s[L%0d] tohost_pulses: got %0d, required %0d", tag, lat_of(i), thn[i], exp_th ? 1 : 0);
            end
            if (exp_th) begin
                tests++;
                if (thdat[i] !== wdata) begin
                    fails++; $display("FAIL %s[L%0d] tohost_data: got %h, required %h", tag, lat_of(i), thdat[i], wdata);
                end
            end
            tests++;
            if (unstable[i]) begin
                fails++; $display("FAIL %s[L%0d] rsp_stable: response changed while waiting, required stable", tag, lat_of(i));
            end
            tests++;
            if (bad_rdy[i]) begin
                fails++; $display("FAIL %s[L%0d] req_ready_busy: seen 1 while busy, required 0", tag, lat_of(i));
            end
            tests++;
            if (bad_post[i]) begin
                fails++; $display("FAIL %s[L%0d] after_handshake: rsp_valid/req_ready wrong, required 0/1", tag, lat_of(i));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({req_ready, rsp_valid, rsp_fault, mwe, mre, thv, mbw} !== 16'd0) begin
            fails++; $display("FAIL reset_ctrl: got rdy=%b vld=%b flt=%b we=%b re=%b th=%b bw=%h, required all 0",
                              req_ready, rsp_valid, rsp_fault, mwe, mre, thv, mbw);
        end
        tests++;
        if ({rsp_rdata, mwa, mra, mdi, thd} !== '0) begin
            fails++; $display("FAIL reset_data: got nonzero data/address outputs, required 0");
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (req_ready !== 2'b00) begin
            fails++; $display("FAIL reset_release_before_edge: req_ready=%b, required 00", req_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (req_ready !== 2'b11) begin
            fails++; $display("FAIL reset_release_first_edge: req_ready=%b, required 11", req_ready);
        end
    endtask

    task automatic test_store_word();
        do_txn(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 0, "sw_0x100");
    endtask

    task automatic test_load_extend();
        do_txn(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00F0, 0, "sb_seed");
        do_txn(1'b0, 2'b00, 1'b0, 32'h101, 32'd0, 0, "lb_0x101");
        do_txn(1'b0, 2'b00, 1'b1, 32'h101, 32'd0, 0, "lbu_0x101");
        do_txn(1'b1, 2'b01, 1'b0, 32'h104, 32'h1234_9ABC, 0, "sh_0x104");
        do_txn(1'b0, 2'b01, 1'b0, 32'h104, 32'd0, 0, "lh_0x104");
        do_txn(1'b0, 2'b01, 1'b1, 32'h104, 32'd0, 0, "lhu_0x104");
        do_txn(1'b0, 2'b11, 1'b0, 32'h100, 32'd0, 0, "lw_size11");
    endtask

    task automatic test_misaligned();
        do_txn(1'b0, 2'b01, 1'b0, 32'h103, 32'd0, 0, "lh_0x103");
        do_txn(1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 0, "lw_0x102");
        do_txn(1'b1, 2'b01, 1'b0, 32'h101, 32'hFFFF_FFFF, 0, "sh_0x101");
        do_txn(1'b1, 2'b10, 1'b0, 32'h103, 32'hFFFF_FFFF, 0, "sw_0x103");
    endtask

    task automatic test_tohost();
        do_txn(1'b1, 2'b00, 1'b0, TOHOST, 32'h0000_0041, 0, "sb_tohost");
        do_txn(1'b1, 2'b10, 1'b0, TOHOST, 32'hCAFE_F00D, 0, "sw_tohost");
    endtask

    task automatic test_backpressure();
        do_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 5, "lw_hold5");
        do_txn(1'b1, 2'b10, 1'b0, 32'h108, 32'h0BAD_F00D, 3, "sw_hold3");
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        seen = 0;
        rsp_ready = 2'b00;
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h200; req_wdata = 32'd0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (mre[1] !== 1'b1) begin
            fails++; $display("FAIL midread_active: mem_read_enable=%b, required 1", mre[1]);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (mre !== 2'b00 || mwe !== 2'b00 || rsp_valid !== 2'b00) begin
            fails++; $display("FAIL midread_reset_drop: re=%b we=%b vld=%b, required 00", mre, mwe, rsp_valid);
        end
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid !== 2'b00) seen = 1;
        end
        tests++;
        if (seen) begin
            fails++; $display("FAIL midread_no_rsp: rsp_valid seen during reset, required none");
        end
        @(negedge clk);
        rst = 1'b1;
        do_txn(1'b0, 2'b10, 1'b0, 32'h200, 32'd0, 0, "lw_0x200_after_reset");
    endtask

    task automatic test_random();
        logic        we, uns;
        logic [1:0]  size;
        logic [31:0] addr;
        for (int n = 0; n < 80; n++) begin
            we   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = 32'h100 + 32'($urandom_range(0, 250));
            if (we && $urandom_range(0, 9) == 0) addr = TOHOST;
            do_txn(we, size, uns, addr, $urandom, int'($urandom_range(0, 3)), "rand");
        end
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) ref_mem[k] = init_byte(k);
        test_reset();
        test_store_word();
        test_load_extend();
        test_misaligned();
        test_tohost();
        test_backpressure();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end
endmodule
